// File: rtl/tlm_pkg.sv
// Shared lamp encodings, phase enum, fault codes and decode/sequence helpers
// for the traffic light monitor.
package tlm_pkg;

  localparam logic [2:0] S_OFF    = 3'b000;
  localparam logic [2:0] S_GREEN  = 3'b001;
  localparam logic [2:0] S_YELLOW = 3'b010;
  localparam logic [2:0] S_RED    = 3'b100;

  localparam logic [1:0] W_OFF    = 2'b00;
  localparam logic [1:0] W_GREEN  = 2'b01;
  localparam logic [1:0] W_RED    = 2'b10;

  typedef enum logic [2:0] {
    PH_UNK   = 3'd0,
    PH_A_GRN = 3'd1,
    PH_A_YEL = 3'd2,
    PH_B_GRN = 3'd3,
    PH_B_YEL = 3'd4,
    PH_WALK  = 3'd5,
    PH_CLEAR = 3'd6,
    PH_DARK  = 3'd7
  } phase_t;

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_ILLEGAL     = 3'd1;
  localparam logic [2:0] FC_CONFLICT    = 3'd2;
  localparam logic [2:0] FC_BAD_SEQ     = 3'd3;
  localparam logic [2:0] FC_DWELL_SHORT = 3'd4;
  localparam logic [2:0] FC_DWELL_LONG  = 3'd5;

  function automatic logic lamp_ok(input logic [2:0] s);
    return s inside {S_OFF, S_GREEN, S_YELLOW, S_RED};
  endfunction

  function automatic phase_t decode_phase(input logic [2:0] a, input logic [2:0] b,
                                          input logic [1:0] w);
    phase_t p;
    p = PH_UNK;
    if (a == S_GREEN && b == S_RED && w == W_RED)          p = PH_A_GRN;
    else if (a == S_YELLOW && b == S_RED && w == W_RED)    p = PH_A_YEL;
    else if (a == S_RED && b == S_GREEN && w == W_RED)     p = PH_B_GRN;
    else if (a == S_RED && b == S_YELLOW && w == W_RED)    p = PH_B_YEL;
    else if (a == S_RED && b == S_RED && w == W_GREEN)     p = PH_WALK;
    else if (a == S_RED && b == S_RED && (w == W_RED || w == W_OFF)) p = PH_CLEAR;
    else if (a == S_OFF && b == S_OFF && w == W_OFF)       p = PH_DARK;
    return p;
  endfunction

  // CLEAR is always reachable: the controller may be reset from any phase.
  function automatic logic legal_next(input phase_t cur, input phase_t nxt);
    logic ok;
    ok = 1'b0;
    if (nxt == cur || nxt == PH_CLEAR) ok = 1'b1;
    else begin
      case (cur)
        PH_A_GRN: ok = (nxt == PH_A_YEL);
        PH_A_YEL: ok = (nxt == PH_B_GRN);
        PH_B_GRN: ok = (nxt == PH_B_YEL);
        PH_B_YEL: ok = (nxt == PH_WALK);
        PH_CLEAR: ok = (nxt == PH_A_GRN) || (nxt == PH_DARK);
        default:  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/tlm_dwell_counter.sv
// Saturating tick counter; restart loads 1 (the first tick of a new phase).
module tlm_dwell_counter #(
  parameter int unsigned W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         restart,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST)                      count <= '0;
    else if (restart)             count <= W'(1);
    else if (count != {W{1'b1}})  count <= count + W'(1);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Light-bus observer: decodes phase, checks safety/sequence/dwell, latches first fault.
// Dwell-time checking is enabled by defining TLM_DWELL_CHECK_EN.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int unsigned GREEN_TICKS = 12,
  parameter int unsigned YEL_A_TICKS = 8,
  parameter int unsigned YEL_B_TICKS = 4,
  parameter int unsigned WALK_TICKS  = 8,
  parameter int unsigned TOL         = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       lighta,
  input  logic [2:0]       lightb,
  input  logic [1:0]       lightw,
  input  logic             clr_fault,
  output logic [2:0]       phase,
  output logic             synced,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [3:0]       dwell,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned DWELL_W = 4;

`ifdef TLM_DWELL_CHECK_EN
  localparam bit DWELL_CHECK = 1'b1;
`else
  localparam bit DWELL_CHECK = 1'b0;
`endif

  logic [2:0] la_q, lb_q;
  logic [1:0] lw_q;
  logic       clr_q;
  phase_t     phase_q, cur;
  logic       changed, illegal, conflict, bad_seq, dwell_short, dwell_long;
  logic [2:0] det_code;

  function automatic logic is_timed(input phase_t p);
    return p inside {PH_A_GRN, PH_A_YEL, PH_B_GRN, PH_B_YEL, PH_WALK};
  endfunction

  function automatic int unsigned exp_ticks(input phase_t p);
    int unsigned t;
    case (p)
      PH_A_GRN, PH_B_GRN: t = GREEN_TICKS;
      PH_A_YEL:           t = YEL_A_TICKS;
      PH_B_YEL:           t = YEL_B_TICKS;
      PH_WALK:            t = WALK_TICKS;
      default:            t = 0;
    endcase
    return t;
  endfunction

  tlm_dwell_counter #(.W(DWELL_W)) u_dwell (
    .CLK     (CLK),
    .RST     (RST),
    .restart (changed),
    .count   (dwell)
  );

  // Checks on the registered sample; lowest fault code takes priority.
  always_comb begin
    cur      = decode_phase(la_q, lb_q, lw_q);
    changed  = (cur != phase_q);
    illegal  = !lamp_ok(la_q) || !lamp_ok(lb_q) || (lw_q == 2'b11);
    conflict = ((la_q inside {S_GREEN, S_YELLOW}) && (lb_q inside {S_GREEN, S_YELLOW}))
            || (lw_q == W_GREEN && (la_q != S_RED || lb_q != S_RED));
    bad_seq  = synced && changed && !legal_next(phase_q, cur);
    // A non-WALK exit straight into CLEAR is a controller reset, not a short dwell.
    dwell_short = DWELL_CHECK && synced && changed && is_timed(phase_q)
               && !(cur == PH_CLEAR && phase_q != PH_WALK)
               && (32'(dwell) + TOL < exp_ticks(phase_q));
    dwell_long  = DWELL_CHECK && synced && !changed && is_timed(phase_q)
               && (32'(dwell) == exp_ticks(phase_q) + TOL);
    det_code = FC_NONE;
    if (illegal)          det_code = FC_ILLEGAL;
    else if (conflict)    det_code = FC_CONFLICT;
    else if (bad_seq)     det_code = FC_BAD_SEQ;
    else if (dwell_short) det_code = FC_DWELL_SHORT;
    else if (dwell_long)  det_code = FC_DWELL_LONG;
  end

  assign phase = phase_q;

  // Input sample registers plus sync/fault tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      la_q        <= S_OFF;
      lb_q        <= S_OFF;
      lw_q        <= W_OFF;
      clr_q       <= 1'b0;
      phase_q     <= PH_UNK;
      synced      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      cycle_count <= '0;
    end else begin
      la_q    <= lighta;
      lb_q    <= lightb;
      lw_q    <= lightw;
      clr_q   <= clr_fault;
      phase_q <= cur;

      if (det_code != FC_NONE && (!fault || clr_q)) begin
        fault      <= 1'b1;
        fault_code <= det_code;
      end else if (clr_q) begin
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end

      if (det_code != FC_NONE || clr_q)
        synced <= 1'b0;
      else if (!fault && changed && cur == PH_A_GRN)
        synced <= 1'b1;

      if (synced && changed && phase_q == PH_CLEAR && cur == PH_A_GRN)
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule
